// File: rtl/pwm_driver.sv
// Motor PWM generator on the consuming side of the PID pwm_update/pwm_ratio/pwm_direction/pwm_done handshake.
// Duty and direction change only at period boundaries; a reversal while driven coasts for DEADTIME_PERIODS periods.
module pwm_driver #(
  parameter int CLK_DIV          = 4,
  parameter int DEADTIME_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out,
  output logic       period_start,
  output logic [7:0] active_ratio
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] DEADTIME = 2'd2;

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DT_W = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;

  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(CLK_DIV - 1);
  localparam logic [DT_W-1:0] DT_LAST    = DT_W'((DEADTIME_PERIODS > 0) ? DEADTIME_PERIODS - 1 : 0);
  localparam logic [7:0]      COUNT_LAST = 8'd254;
  localparam logic            DT_EN      = (DEADTIME_PERIODS > 0);

  logic [1:0]      state;
  logic [PS_W-1:0] prescaler;
  logic [PS_W-1:0] prescaler_nxt;
  logic [7:0]      count;
  logic [7:0]      count_nxt;
  logic            first_run;
  logic [DT_W-1:0] dt_count;
  logic [7:0]      pending_ratio;
  logic            pending_dir;
  logic            tick;
  logic            wrap;
  logic            boundary;
  logic            reversal;

  always_comb begin
    tick          = (prescaler == PS_LAST);
    wrap          = tick && (count == COUNT_LAST);
    prescaler_nxt = tick ? '0 : prescaler + 1'b1;
    count_nxt     = count;
    if (tick) begin
      count_nxt = (count == COUNT_LAST) ? 8'd0 : count + 8'd1;
    end
    // The first RUN clock after IDLE is a boundary so a waiting request is taken without a full-period wait.
    boundary = ((state == RUN) && first_run) ||
               (((state == RUN) || (state == DEADTIME)) && wrap);
    // A reversal only needs coasting when the bridge is actually being driven.
    reversal = DT_EN && (pwm_direction != dir_out) && (active_ratio != 8'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      prescaler     <= '0;
      count         <= '0;
      first_run     <= 1'b0;
      dt_count      <= '0;
      pending_ratio <= '0;
      pending_dir   <= 1'b0;
      active_ratio  <= '0;
      dir_out       <= 1'b0;
      pwm_out       <= 1'b0;
      pwm_done      <= 1'b0;
      period_start  <= 1'b0;
    end else if (!pwm_enable) begin
      // Disable wins over any simultaneous boundary, update or dead-time completion.
      state         <= IDLE;
      prescaler     <= '0;
      count         <= '0;
      first_run     <= 1'b0;
      dt_count      <= '0;
      pending_ratio <= '0;
      pending_dir   <= 1'b0;
      active_ratio  <= '0;
      pwm_out       <= 1'b0;
      pwm_done      <= 1'b0;
      period_start  <= 1'b0;
    end else begin
      pwm_done     <= 1'b0;
      period_start <= boundary;
      pwm_out      <= (state == RUN) && (count < active_ratio);
      case (state)
        IDLE: begin
          state        <= RUN;
          prescaler    <= '0;
          count        <= '0;
          first_run    <= 1'b1;
          active_ratio <= '0;
        end
        RUN: begin
          prescaler <= prescaler_nxt;
          count     <= count_nxt;
          first_run <= 1'b0;
          if (boundary && pwm_update) begin
            if (reversal) begin
              pending_ratio <= pwm_ratio;
              pending_dir   <= pwm_direction;
              dt_count      <= '0;
              state         <= DEADTIME;
              pwm_out       <= 1'b0;
            end else begin
              active_ratio <= pwm_ratio;
              dir_out      <= pwm_direction;
              pwm_done     <= 1'b1;
            end
          end
        end
        DEADTIME: begin
          prescaler <= prescaler_nxt;
          count     <= count_nxt;
          if (boundary) begin
            if (dt_count == DT_LAST) begin
              active_ratio <= pending_ratio;
              dir_out      <= pending_dir;
              state        <= RUN;
              pwm_done     <= 1'b1;
            end else begin
              dt_count <= dt_count + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  done_single_pulse: assert property (@(posedge clock) disable iff (!reset_n) pwm_done |=> !pwm_done);

endmodule

// File: tb/tb_pwm_driver.sv
// Bench for pwm_driver: request table plus scoreboard of expected acknowledged ratio/direction,
// with hand-written sequences for dead-time, disable/re-enable and asynchronous reset.
module tb_pwm_driver;
  localparam int CLK_DIV          = 4;
  localparam int DEADTIME_PERIODS = 2;
  localparam int PERIOD           = 255 * CLK_DIV;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pwm_enable;
  logic       pwm_update;
  logic [7:0] pwm_ratio;
  logic       pwm_direction;
  logic       pwm_done;
  logic       pwm_out;
  logic       dir_out;
  logic       period_start;
  logic [7:0] active_ratio;

  always #5 clock = ~clock;

  pwm_driver #(.CLK_DIV(CLK_DIV), .DEADTIME_PERIODS(DEADTIME_PERIODS)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pwm_enable    (pwm_enable),
    .pwm_update    (pwm_update),
    .pwm_ratio     (pwm_ratio),
    .pwm_direction (pwm_direction),
    .pwm_done      (pwm_done),
    .pwm_out       (pwm_out),
    .dir_out       (dir_out),
    .period_start  (period_start),
    .active_ratio  (active_ratio)
  );

  typedef struct { logic [7:0] ratio; logic dir; int exp_high; } vec_t;
  typedef struct { logic [7:0] ratio; logic dir; } req_t;

  req_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  // Observation of the output stream, sampled mid-cycle.
  int         cyc        = 0;
  int         acc        = 0;
  int         last_high  = 0;
  int         last_len   = 0;
  int         ps_cyc     = 0;
  int         ps_count   = 0;
  int         done_count = 0;
  int         consec     = 0;
  logic [7:0] done_ratio = 8'd0;
  logic       done_dir   = 1'b0;
  logic       prev_done  = 1'b0;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (period_start) begin
      last_high <= acc + int'(pwm_out);
      acc       <= 0;
      last_len  <= cyc - ps_cyc;
      ps_cyc    <= cyc;
      ps_count  <= ps_count + 1;
    end else begin
      acc <= acc + int'(pwm_out);
    end
    if (pwm_done) begin
      done_count <= done_count + 1;
      done_ratio <= active_ratio;
      done_dir   <= dir_out;
    end
    consec    <= consec + int'(pwm_done && prev_done);
    prev_done <= pwm_done;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_periods(input string name, input int n);
    int target;
    int left;
    target = ps_count + n;
    left   = n * (PERIOD + 80) + 10;
    while (ps_count < target && left > 0) begin
      @(posedge clock); #1;
      left--;
    end
    check({name, "_period_seen"}, int'(ps_count >= target), 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int   start;
    int   left;
    req_t e;
    start = done_count;
    left  = budget;
    while (done_count == start && left > 0) begin
      @(posedge clock); #1;
      left--;
    end
    check({name, "_done"}, done_count - start, 1);
    if (done_count != start && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_ratio"}, int'(done_ratio), int'(e.ratio));
      check({name, "_dir"}, int'(done_dir), int'(e.dir));
    end
  endtask

  task automatic push_req(input logic [7:0] r, input logic d);
    req_t e;
    e.ratio = r;
    e.dir   = d;
    sb.push_back(e);
    pwm_ratio     = r;
    pwm_direction = d;
    pwm_update    = 1'b1;
  endtask

  initial begin
    int d0;
    int t0;
    int hi;
    int left;

    vecs[0] = '{ratio: 8'd128, dir: 1'b0, exp_high: 512};
    vecs[1] = '{ratio: 8'd128, dir: 1'b0, exp_high: 512};
    vecs[2] = '{ratio: 8'd0,   dir: 1'b0, exp_high: 0};
    vecs[3] = '{ratio: 8'd255, dir: 1'b0, exp_high: 1020};
    vecs[4] = '{ratio: 8'd100, dir: 1'b0, exp_high: 400};

    reset_n       = 1'b0;
    pwm_enable    = 1'b0;
    pwm_update    = 1'b0;
    pwm_ratio     = 8'd0;
    pwm_direction = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_dir_out", int'(dir_out), 0);
    check("rst_pwm_done", int'(pwm_done), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_active_ratio", int'(active_ratio), 0);

    reset_n = 1'b1;
    hi = 0;
    repeat (50) begin
      @(posedge clock); #1;
      hi += int'(pwm_out) + int'(period_start);
    end
    check("idle_quiet", hi, 0);

    // Enable with a waiting request: acknowledged two clocks later.
    push_req(vecs[0].ratio, vecs[0].dir);
    pwm_enable = 1'b1;
    @(posedge clock); #1;
    check("enable_done_lag1", int'(pwm_done), 0);
    @(posedge clock); #1;
    check("enable_done_lag2", int'(pwm_done), 1);
    check("enable_active_ratio", int'(active_ratio), 128);
    wait_done("v0", 5);

    for (int i = 1; i < 5; i++) begin
      push_req(vecs[i].ratio, vecs[i].dir);
      wait_done($sformatf("v%0d", i), PERIOD + 80);
      if (i >= 2) begin
        check($sformatf("v%0d_high", i - 1), last_high, vecs[i - 1].exp_high);
        check($sformatf("v%0d_len", i - 1), last_len, PERIOD);
      end
    end
    pwm_update = 1'b0;
    wait_periods("v4", 1);
    check("v4_high", last_high, vecs[4].exp_high);

    // Ratio change without update is not taken.
    pwm_ratio = 8'd200;
    d0 = done_count;
    wait_periods("noupd", 2);
    check("noupd_active_ratio", int'(active_ratio), 100);
    check("noupd_no_done", done_count - d0, 0);
    check("noupd_high", last_high, 400);

    // Reversal while driven: two coast periods, single acknowledge.
    push_req(8'd60, 1'b1);
    d0 = done_count;
    wait_periods("dt_b0", 1);
    t0 = ps_cyc;
    pwm_ratio     = 8'd7;
    pwm_direction = 1'b0;
    pwm_update    = 1'b1;
    check("dt_hold_ratio", int'(active_ratio), 100);
    check("dt_hold_dir", int'(dir_out), 0);
    check("dt_pwm_low", int'(pwm_out), 0);
    wait_periods("dt_b1", 1);
    check("dt_low1_high", last_high, 0);
    check("dt_b1_dir", int'(dir_out), 0);
    check("dt_b1_no_done", done_count - d0, 0);
    pwm_update = 1'b0;
    wait_done("dt", PERIOD + 80);
    check("dt_low2_high", last_high, 0);
    check("dt_span", ps_cyc - t0, 2 * PERIOD);
    check("dt_active_ratio", int'(active_ratio), 60);
    check("dt_dir_out", int'(dir_out), 1);
    wait_periods("dt_after", 1);
    check("dt_after_high", last_high, 240);

    // Drop enable on the clock of a boundary that carries a same-direction update.
    pwm_ratio     = 8'd90;
    pwm_direction = 1'b1;
    pwm_update    = 1'b1;
    repeat (PERIOD - 2) @(posedge clock);
    #1;
    pwm_enable = 1'b0;
    d0 = done_count;
    @(posedge clock); #1;
    check("drop_pwm_out", int'(pwm_out), 0);
    check("drop_active_ratio", int'(active_ratio), 0);
    check("drop_pwm_done", int'(pwm_done), 0);
    check("drop_period_start", int'(period_start), 0);
    check("drop_dir_hold", int'(dir_out), 1);
    repeat (5) @(posedge clock);
    #1;
    check("drop_no_done", done_count - d0, 0);

    // Re-enable with the opposite direction: no coast because nothing is driven.
    push_req(8'd90, 1'b0);
    pwm_enable = 1'b1;
    @(posedge clock); #1;
    check("reen_done_lag1", int'(pwm_done), 0);
    @(posedge clock); #1;
    check("reen_done_lag2", int'(pwm_done), 1);
    check("reen_dir_out", int'(dir_out), 0);
    wait_done("reen", 5);
    pwm_update = 1'b0;
    wait_periods("reen", 2);
    check("reen_high", last_high, 360);
    check("reen_len", last_len, PERIOD);

    // Asynchronous reset while the output is high.
    left = PERIOD + 80;
    while (!pwm_out && left > 0) begin
      @(posedge clock); #1;
      left--;
    end
    check("pre_reset_pwm_high", int'(pwm_out), 1);
    #2;
    reset_n    = 1'b0;
    pwm_enable = 1'b0;
    #1;
    check("arst_pwm_out", int'(pwm_out), 0);
    check("arst_dir_out", int'(dir_out), 0);
    check("arst_pwm_done", int'(pwm_done), 0);
    check("arst_period_start", int'(period_start), 0);
    check("arst_active_ratio", int'(active_ratio), 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    hi = 0;
    repeat (50) begin
      @(posedge clock); #1;
      hi += int'(pwm_out);
    end
    check("post_reset_low", hi, 0);

    check("scoreboard_drained", sb.size(), 0);
    check("done_back_to_back", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
